cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 68 ++++++
 tb/tb_cdb_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that picks one functional-unit result per cycle
// and broadcasts its tag and data on the registered common data bus.
module cdb_arbiter #(
    parameter int N_UNITS = 4,
    parameter int Data_Width = 32,
    parameter int Reg_Lock_Width = 5,
    parameter logic [Reg_Lock_Width-1:0] Reg_No_Lock = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [N_UNITS-1:0]                 req_valid,
    input  logic [N_UNITS*Reg_Lock_Width-1:0]  req_index,
    input  logic [N_UNITS*Data_Width-1:0]      req_result,
    output logic [N_UNITS-1:0]                 grnt,
    output logic [Reg_Lock_Width-1:0]          cdb_index,
    output logic [Data_Width-1:0]              cdb_result,
    output logic                               cdb_valid
);
    localparam int PW = N_UNITS > 1 ? $clog2(N_UNITS) : 1;

    logic [PW-1:0]             rr_ptr;
    logic [PW-1:0]             win;
    logic [PW-1:0]             nxt_ptr;
    logic                      found;
    logic                      take;
    logic [Reg_Lock_Width-1:0] win_index;
    logic [Data_Width-1:0]     win_result;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % N_UNITS]) begin
                found = 1'b1;
                win   = PW'((int'(rr_ptr) + k) % N_UNITS);
            end
        end
    end

    // Grant is gated by reset so the bus stays quiet while rst_n is held low.
    assign take       = found && !flush && rst_n;
    assign grnt       = take ? (N_UNITS'(1) << win) : '0;
    assign win_index  = req_index[win*Reg_Lock_Width +: Reg_Lock_Width];
    assign win_result = req_result[win*Data_Width +: Data_Width];
    assign nxt_ptr    = (int'(win) == N_UNITS - 1) ? '0 : win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid  <= 1'b0;
            cdb_index  <= Reg_No_Lock;
            cdb_result <= '0;
            rr_ptr     <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            cdb_index <= Reg_No_Lock;
            rr_ptr    <= '0;
        end else if (found) begin
            cdb_valid  <= win_index != Reg_No_Lock;
            cdb_index  <= win_index;
            cdb_result <= win_result;
            rr_ptr     <= nxt_ptr;
        end else begin
            cdb_valid <= 1'b0;
            cdb_index <= Reg_No_Lock;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a
// behavioural round-robin bus model.
module tb_cdb_arbiter;
    localparam int N = 4, DW = 32, LW = 5;

    logic            clk = 0, rst_n = 0, flush = 0;
    logic [N-1:0]    req_valid = '0, grnt;
    logic [N*LW-1:0] req_index = '0;
    logic [N*DW-1:0] req_result = '0;
    logic [LW-1:0]   cdb_index;
    logic [DW-1:0]   cdb_result;
    logic            cdb_valid;

    int n_chk = 0, n_pass = 0;
    int m_ptr = 0;
    logic          m_valid = 0;
    logic [LW-1:0] m_index = '0;
    logic [DW-1:0] m_result = '0;

    cdb_arbiter #(.N_UNITS(N), .Data_Width(DW), .Reg_Lock_Width(LW), .Reg_No_Lock('0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid),
        .req_index(req_index), .req_result(req_result), .grnt(grnt),
        .cdb_index(cdb_index), .cdb_result(cdb_result), .cdb_valid(cdb_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic set_unit(input int u, input logic [LW-1:0] tag, input logic [DW-1:0] res);
        req_index[u*LW +: LW]  = tag;
        req_result[u*DW +: DW] = res;
    endtask

    // Expected winner: first requesting unit scanning upward from the model pointer.
    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic cycle(input logic [N-1:0] v, input logic f, input string tag);
        int w;
        logic [N-1:0]  eg;
        logic [LW-1:0] t;
        logic [DW-1:0] r;
        req_valid = v;
        flush = f;
        #1;
        w = f ? -1 : pick();
        eg = '0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            t = req_index[w*LW +: LW];
            r = req_result[w*DW +: DW];
        end
        chk({tag, ".grnt"}, 64'(grnt), 64'(eg));
        @(posedge clk);
        #1;
        if (f) begin
            m_valid = 0; m_index = '0; m_ptr = 0;
        end else if (w >= 0) begin
            m_index = t; m_result = r; m_valid = (t != '0); m_ptr = (w + 1) % N;
        end else begin
            m_valid = 0; m_index = '0;
        end
        chk({tag, ".valid"}, 64'(cdb_valid), 64'(m_valid));
        chk({tag, ".index"}, 64'(cdb_index), 64'(m_index));
        chk({tag, ".result"}, 64'(cdb_result), 64'(m_result));
    endtask

    initial begin
        #2;
        req_valid = 4'b1111;
        #1;
        chk("rst.grnt", 64'(grnt), 64'h0);
        chk("rst.valid", 64'(cdb_valid), 64'h0);
        chk("rst.index", 64'(cdb_index), 64'h0);
        chk("rst.result", 64'(cdb_result), 64'h0);
        req_valid = '0;
        rst_n = 1;

        set_unit(0, 5'd3, 32'h0000_0001);
        cycle(4'b0001, 0, "single");
        chk("single.exp_tag", 64'(cdb_index), 64'd3);

        for (int u = 0; u < N; u++) set_unit(u, LW'(u + 10), DW'(32'hA000_0000 + u));
        for (int i = 0; i < 8; i++) cycle(4'b1111, 0, $sformatf("rr%0d", i));

        cycle(4'b0010, 0, "ptr2");
        cycle(4'b1010, 0, "wrap_a");
        chk("wrap_a.exp_tag", 64'(cdb_index), 64'd13);
        cycle(4'b1010, 0, "wrap_b");
        chk("wrap_b.exp_tag", 64'(cdb_index), 64'd11);

        cycle(4'b0000, 0, "idle");
        set_unit(1, 5'd0, 32'hDEAD_BEEF);
        cycle(4'b1111, 0, "advance");
        cycle(4'b0010, 0, "nolock");
        cycle(4'b1111, 1, "flush");
        cycle(4'b1111, 0, "post_flush");
        chk("post_flush.exp_tag", 64'(cdb_index), 64'd10);

        set_unit(2, 5'd7, 32'h1234_5678);
        cycle(4'b0100, 0, "pre_areset");
        #2;
        rst_n = 0;
        req_valid = 4'b1111;
        #1;
        chk("areset.valid", 64'(cdb_valid), 64'h0);
        chk("areset.index", 64'(cdb_index), 64'h0);
        chk("areset.result", 64'(cdb_result), 64'h0);
        chk("areset.grnt", 64'(grnt), 64'h0);
        m_valid = 0; m_index = '0; m_result = '0; m_ptr = 0;
        #1;
        rst_n = 1;

        for (int i = 0; i < 400; i++) begin
            for (int u = 0; u < N; u++)
                set_unit(u, ($urandom % 4 == 0) ? LW'(0) : LW'($urandom), DW'($urandom));
            cycle(N'($urandom), ($urandom % 8 == 0), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
